dropbox_fifo: RTL and testbench
===============================

DROPBOX_FIFO -- requirements
Module: dropbox_fifo

Interface
REQ-001 The block SHALL have parameter DEVADDR1, default 8'h28, meaning side-1 base address on bus 1.
REQ-002 The block SHALL have parameter DEVADDR2, default 8'h28, meaning side-2 base address on bus 2.
REQ-003 The block SHALL have parameter DEPTH, default 16, meaning entries per direction; power of two, 2..256.
REQ-004 The block SHALL have these ports:
- clk  in  1  sole clock; all state updates on its rising edge.
- reset  in  1  synchronous, active-high reset.
- OUTBUS_ADDR1 / OUTBUS_ADDR2  in  8  side-n write address.
- OUTBUS_DATA1 / OUTBUS_DATA2  in  8  side-n write data.
- OUTBUS_WE1 / OUTBUS_WE2  in  1  side-n write strobe.
- INBUS_ADDR1 / INBUS_ADDR2  in  8  side-n read address.
- INBUS_DATA1 / INBUS_DATA2  out  8  side-n read data; OR-combined with other devices.
- INBUS_RE1 / INBUS_RE2  in  1  side-n read strobe.

Function
REQ-005 The block SHALL contain two independent FIFOs of DEPTH x 8 bits: F12 (side 1 to side 2) and F21 (side 2 to side 1).
REQ-006 Each side SHALL see a register map relative to its base B: B+0 DATA, B+1 STATUS.
REQ-007 A side-1 write to DATA (WE1=1, ADDR1=DEVADDR1) SHALL push OUTBUS_DATA1 into F12 at the clock edge; side 2 pushes into F21 symmetrically.
REQ-008 A side-1 read of DATA (RE1=1, ADDR1=DEVADDR1) SHALL drive the F21 head on INBUS_DATA1 combinationally in the same cycle and pop it at the clock edge; side 2 reads F12 symmetrically.
REQ-009 A read strobe held N consecutive cycles SHALL pop N entries, one per cycle.
REQ-010 INBUS_DATAn SHALL be 8'h00 whenever INBUS_REn=0 or the address matches neither DATA nor STATUS.
REQ-011 STATUS read SHALL return: bit0 = own RX FIFO not empty; bit1 = own TX FIFO full; bit2 = sticky TX overflow; bit3 = sticky RX underflow; bits7:4 = own RX count, saturated at 15.
REQ-012 A STATUS write SHALL clear bit2 and/or bit3 where the corresponding data bit is 1 (write-1-to-clear).
REQ-013 A STATUS write with data bit7=1 SHALL flush that side's RX FIFO (count 0, pointers equal) at the edge.
REQ-014 A push to a full FIFO SHALL be dropped, leave contents unchanged, and set the writer's overflow flag.
REQ-015 A pop from an empty FIFO SHALL return 8'h00, leave pointers unchanged, and set the reader's underflow flag.
REQ-016 A simultaneous push and pop on one FIFO SHALL both take effect with count unchanged, including when full; when empty, the push succeeds, the pop follows REQ-015, and the resulting count is 1.
REQ-017 A flush coinciding with a push into the same FIFO SHALL give the flush priority: resulting count 0, push discarded, no overflow flag.
REQ-018 A sticky-flag set and a W1C clear of the same flag in the same cycle SHALL leave the flag set.
REQ-019 Read/write pointers SHALL be log2(DEPTH) bits and wrap modulo DEPTH; the count SHALL be log2(DEPTH)+1 bits, ranging 0..DEPTH.
REQ-020 DEVADDR1 and DEVADDR2 MAY be equal; the two buses SHALL never interact except through the FIFOs.
REQ-021 Status changes caused by a push or pop SHALL be visible on a STATUS read in the cycle after the causing edge.

Reset
REQ-022 While reset=1 at an edge, both FIFOs SHALL become empty, all sticky flags 0, and all bus pushes, pops and flushes SHALL be ignored.
REQ-023 INBUS_DATA1/2 SHALL follow REQ-010 during and after reset; a STATUS read in the first cycle after reset SHALL return 8'h00.
REQ-024 Reset asserted mid-transfer SHALL discard all queued data; FIFO memory contents need not be cleared.

Verification
REQ-025 DEPTH=16: side 1 writes 8'hA5, then 8'h3C; side 2 reads DATA twice -> 8'hA5 then 8'h3C; then side-2 STATUS = 8'h00.
REQ-026 DEPTH=4: side 2 writes 5 bytes 1..5 -> side-2 STATUS = 8'h06 (full, overflow); side 1 reads -> 1,2,3,4; a fifth read -> 8'h00 and side-1 STATUS bit3=1.
REQ-027 With F12 full (DEPTH=4): side 1 writes 8'h77 in the same cycle that side 2 pops -> count remains 4, no overflow, last entry read = 8'h77.
REQ-028 Side-2 RX count 3: side 2 writes STATUS 8'h80 -> next side-2 STATUS bit0=0, bits7:4=0; side-1 traffic in F21 unaffected.
REQ-029 Overflow flag set: W1C with 8'h04 -> bit2=0; W1C concurrent with a new overflow -> bit2 stays 1.
REQ-030 Queue 3 bytes each way, assert reset one cycle -> both STATUS read 8'h00; non-matching address reads -> 8'h00 throughout.

Source files
------------

// File: rtl/dropbox_fifo.sv
// dropbox_fifo: bidirectional mailbox between two independent 8-bit buses.
// Index 0 of every per-side array is side 1, index 1 is side 2. FIFO f is
// written by side f and read (and flushed) by the opposite side.
module dropbox_fifo #(
  parameter logic [7:0] DEVADDR1 = 8'h28,
  parameter logic [7:0] DEVADDR2 = 8'h28,
  parameter int         DEPTH    = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] OUTBUS_ADDR1,
  input  logic [7:0] OUTBUS_ADDR2,
  input  logic [7:0] OUTBUS_DATA1,
  input  logic [7:0] OUTBUS_DATA2,
  input  logic       OUTBUS_WE1,
  input  logic       OUTBUS_WE2,
  input  logic [7:0] INBUS_ADDR1,
  input  logic [7:0] INBUS_ADDR2,
  output logic [7:0] INBUS_DATA1,
  output logic [7:0] INBUS_DATA2,
  input  logic       INBUS_RE1,
  input  logic       INBUS_RE2
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  // RX count as shown in STATUS bits 7:4, clipped at 15
  function automatic logic [3:0] sat_count(input logic [CW-1:0] c);
    if (int'(c) >= 15) return 4'hF;
    return 4'(c);
  endfunction

  // Bus signals gathered into side-indexed arrays
  logic [1:0][7:0] out_addr;
  logic [1:0][7:0] out_data;
  logic [1:0][7:0] in_addr;
  logic [1:0][7:0] in_data;
  logic [1:0]      we;
  logic [1:0]      re;

  assign out_addr    = {OUTBUS_ADDR2, OUTBUS_ADDR1};
  assign out_data    = {OUTBUS_DATA2, OUTBUS_DATA1};
  assign in_addr     = {INBUS_ADDR2, INBUS_ADDR1};
  assign we          = {OUTBUS_WE2, OUTBUS_WE1};
  assign re          = {INBUS_RE2, INBUS_RE1};
  assign INBUS_DATA1 = in_data[0];
  assign INBUS_DATA2 = in_data[1];

  // Per-side decoded bus requests
  logic [1:0] push_req;   // side writes DATA
  logic [1:0] stat_wr;    // side writes STATUS
  logic [1:0] pop_req;    // side reads DATA
  logic [1:0] stat_rd;    // side reads STATUS
  logic [1:0] flush_req;  // side flushes its RX FIFO

  // Per-FIFO state exported from the generate blocks
  logic [1:0]          fifo_full;
  logic [1:0]          fifo_empty;
  logic [1:0]          fifo_ovf;   // push into FIFO f dropped (charged to side f)
  logic [1:0]          fifo_unf;   // pop of empty FIFO f (charged to the reader)
  logic [1:0][7:0]     head_data;
  logic [1:0][CW-1:0]  fifo_count;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_side
      localparam logic [7:0] BASE = (gi == 0) ? DEVADDR1 : DEVADDR2;
      localparam logic [7:0] STAT = BASE + 8'd1;
      localparam int         PEER = 1 - gi;

      // ---------------- address decode for side gi ----------------
      assign push_req[gi]  = we[gi] && (out_addr[gi] == BASE);
      assign stat_wr[gi]   = we[gi] && (out_addr[gi] == STAT);
      assign pop_req[gi]   = re[gi] && (in_addr[gi] == BASE);
      assign stat_rd[gi]   = re[gi] && (in_addr[gi] == STAT);
      assign flush_req[gi] = stat_wr[gi] && out_data[gi][7];

      // ---------------- FIFO gi: written by side gi ----------------
      logic [7:0]    mem_reg [DEPTH];
      logic [AW-1:0] wr_ptr_reg;
      logic [AW-1:0] rd_ptr_reg;
      logic [CW-1:0] count_reg;
      logic          flush;
      logic          pop;
      logic          do_push;
      logic          do_pop;

      assign flush          = flush_req[PEER];
      assign pop            = pop_req[PEER];
      assign fifo_full[gi]  = (count_reg == CW'(DEPTH));
      assign fifo_empty[gi] = (count_reg == '0);

      // A pop frees the slot the push fills, so a full FIFO still accepts
      // a push when popped in the same cycle. A flush cancels both.
      assign do_push      = push_req[gi] && !flush && (!fifo_full[gi] || pop);
      assign do_pop       = pop && !flush && !fifo_empty[gi];
      assign fifo_ovf[gi] = push_req[gi] && !flush && fifo_full[gi] && !pop;
      assign fifo_unf[gi] = pop && fifo_empty[gi];

      // Storage write; contents are never cleared, only the pointers are
      always_ff @(posedge clk) begin
        if (!reset && do_push) begin
          mem_reg[wr_ptr_reg] <= out_data[gi];
        end
      end

      // Pointer and occupancy update; flush discards everything queued
      always_ff @(posedge clk) begin
        if (reset) begin
          wr_ptr_reg <= '0;
          rd_ptr_reg <= '0;
          count_reg  <= '0;
        end else if (flush) begin
          rd_ptr_reg <= wr_ptr_reg;
          count_reg  <= '0;
        end else begin
          if (do_push) wr_ptr_reg <= wr_ptr_reg + AW'(1);
          if (do_pop)  rd_ptr_reg <= rd_ptr_reg + AW'(1);
          count_reg <= count_reg + CW'(do_push) - CW'(do_pop);
        end
      end

      // Head is read asynchronously so a DATA read returns it in the same cycle
      assign head_data[gi]  = mem_reg[rd_ptr_reg];
      assign fifo_count[gi] = count_reg;

      // ---------------- sticky flags of side gi ----------------
      logic ovf_reg;
      logic unf_reg;

      // A new error event outranks a same-cycle write-1-to-clear
      always_ff @(posedge clk) begin
        if (reset) begin
          ovf_reg <= 1'b0;
          unf_reg <= 1'b0;
        end else begin
          if (fifo_ovf[gi])
            ovf_reg <= 1'b1;
          else if (stat_wr[gi] && out_data[gi][2])
            ovf_reg <= 1'b0;
          if (fifo_unf[PEER])
            unf_reg <= 1'b1;
          else if (stat_wr[gi] && out_data[gi][3])
            unf_reg <= 1'b0;
        end
      end

      // ---------------- read-back for side gi ----------------
      logic [7:0] status;
      logic [7:0] rd_data;

      assign status = {sat_count(fifo_count[PEER]), unf_reg, ovf_reg,
                       fifo_full[gi], ~fifo_empty[PEER]};

      // Read mux; zero when idle so the bus can be OR-combined
      always_comb begin
        rd_data = 8'h00;
        if (pop_req[gi])
          rd_data = fifo_empty[PEER] ? 8'h00 : head_data[PEER];
        else if (stat_rd[gi])
          rd_data = status;
      end

      assign in_data[gi] = rd_data;
    end
  endgenerate

endmodule

// File: tb/tb_dropbox_fifo.sv
// tb_dropbox_fifo: directed stimulus against a queue-based model of the
// mailbox, plus hand-computed literal read expectations.
module tb_dropbox_fifo;

  localparam int         DEPTH = 4;
  localparam logic [7:0] DA    = 8'h28;
  localparam logic [7:0] SA    = 8'h29;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] oaddr_v [2];
  logic [7:0] odata_v [2];
  logic [7:0] iaddr_v [2];
  logic       we_v    [2];
  logic       re_v    [2];
  logic [7:0] in_data1;
  logic [7:0] in_data2;

  int checks   = 0;
  int failures = 0;

  // Model state
  logic [7:0] q12 [$];
  logic [7:0] q21 [$];
  logic       ovf_m [2];
  logic       unf_m [2];

  // Literal expectations posted by the driver for the current cycle
  logic       lit_en  [2];
  logic [7:0] lit_val [2];
  string      lit_name [2];

  logic [7:0] got;
  logic [7:0] exp_v;

  dropbox_fifo #(.DEVADDR1(DA), .DEVADDR2(DA), .DEPTH(DEPTH)) dut (
    .clk          (clk),
    .reset        (reset),
    .OUTBUS_ADDR1 (oaddr_v[0]),
    .OUTBUS_ADDR2 (oaddr_v[1]),
    .OUTBUS_DATA1 (odata_v[0]),
    .OUTBUS_DATA2 (odata_v[1]),
    .OUTBUS_WE1   (we_v[0]),
    .OUTBUS_WE2   (we_v[1]),
    .INBUS_ADDR1  (iaddr_v[0]),
    .INBUS_ADDR2  (iaddr_v[1]),
    .INBUS_DATA1  (in_data1),
    .INBUS_DATA2  (in_data2),
    .INBUS_RE1    (re_v[0]),
    .INBUS_RE2    (re_v[1])
  );

  always #5 clk = ~clk;

  // ---------------- model helpers (FIFO 0 = side1->side2) ----------------
  function automatic int qsize(int f);
    return (f == 0) ? q12.size() : q21.size();
  endfunction

  function automatic logic [7:0] qhead(int f);
    if (qsize(f) == 0) return 8'h00;
    return (f == 0) ? q12[0] : q21[0];
  endfunction

  function automatic logic [7:0] model_status(int s);
    int n;
    logic [3:0] c;
    n = qsize(1 - s);
    c = (n > 15) ? 4'hF : 4'(n);
    return {c, unf_m[s], ovf_m[s], (qsize(s) == DEPTH), (n != 0)};
  endfunction

  function automatic logic [7:0] model_read(int s);
    if (re_v[s] && iaddr_v[s] == DA) return qhead(1 - s);
    if (re_v[s] && iaddr_v[s] == SA) return model_status(s);
    return 8'h00;
  endfunction

  task automatic model_step();
    logic set_ovf [2];
    logic set_unf [2];
    int   r;
    int   n;
    logic push;
    logic pop;
    logic flush;
    logic w1c;
    if (reset) begin
      q12.delete();
      q21.delete();
      for (int s = 0; s < 2; s++) begin
        ovf_m[s] = 1'b0;
        unf_m[s] = 1'b0;
      end
      return;
    end
    for (int f = 0; f < 2; f++) begin
      r     = 1 - f;
      n     = qsize(f);
      push  = we_v[f] && (oaddr_v[f] == DA);
      pop   = re_v[r] && (iaddr_v[r] == DA);
      flush = we_v[r] && (oaddr_v[r] == SA) && odata_v[r][7];
      set_unf[r] = pop && (n == 0);
      set_ovf[f] = 1'b0;
      if (flush) begin
        if (f == 0) q12.delete(); else q21.delete();
      end else begin
        if (pop && n > 0) begin
          if (f == 0) void'(q12.pop_front()); else void'(q21.pop_front());
        end
        if (push) begin
          if (n < DEPTH || (pop && n > 0)) begin
            if (f == 0) q12.push_back(odata_v[f]); else q21.push_back(odata_v[f]);
          end else begin
            set_ovf[f] = 1'b1;
          end
        end
      end
    end
    for (int s = 0; s < 2; s++) begin
      w1c = we_v[s] && (oaddr_v[s] == SA);
      if (set_ovf[s]) ovf_m[s] = 1'b1;
      else if (w1c && odata_v[s][2]) ovf_m[s] = 1'b0;
      if (set_unf[s]) unf_m[s] = 1'b1;
      else if (w1c && odata_v[s][3]) unf_m[s] = 1'b0;
    end
  endtask

  // Compare process: check both read buses mid-cycle, then advance the model
  always @(negedge clk) begin
    for (int s = 0; s < 2; s++) begin
      got   = (s == 0) ? in_data1 : in_data2;
      exp_v = model_read(s);
      if (!(reset && re_v[s] && (iaddr_v[s] == DA || iaddr_v[s] == SA))) begin
        checks++;
        if (got !== exp_v) begin
          failures++;
          $display("FAIL model_rd side%0d t=%0t got=%h exp=%h", s + 1, $time, got, exp_v);
        end
      end
      if (lit_en[s]) begin
        checks++;
        if (got !== lit_val[s]) begin
          failures++;
          $display("FAIL %s side%0d got=%h exp=%h", lit_name[s], s + 1, got, lit_val[s]);
        end else begin
          $display("txn %s side%0d rd=%h", lit_name[s], s + 1, got);
        end
      end
    end
    model_step();
  end

  // ---------------- driver helpers ----------------
  task automatic idle();
    for (int s = 0; s < 2; s++) begin
      we_v[s]    = 1'b0;
      re_v[s]    = 1'b0;
      oaddr_v[s] = 8'h00;
      odata_v[s] = 8'h00;
      iaddr_v[s] = 8'h00;
      lit_en[s]  = 1'b0;
    end
  endtask

  task automatic wr(int s, logic [7:0] a, logic [7:0] d);
    we_v[s]    = 1'b1;
    oaddr_v[s] = a;
    odata_v[s] = d;
  endtask

  task automatic rd(int s, logic [7:0] a);
    re_v[s]    = 1'b1;
    iaddr_v[s] = a;
  endtask

  task automatic lit(int s, logic [7:0] v, string n);
    lit_en[s]   = 1'b1;
    lit_val[s]  = v;
    lit_name[s] = n;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    idle();
  endtask

  initial begin
    idle();
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    // First cycle after reset
    rd(0, SA); lit(0, 8'h00, "reset_status");
    rd(1, SA); lit(1, 8'h00, "reset_status"); step();

    // Two bytes side1 -> side2
    wr(0, DA, 8'hA5); step();
    wr(0, DA, 8'h3C); rd(1, SA); lit(1, 8'h11, "status_one"); step();
    rd(1, DA); lit(1, 8'hA5, "data_first"); step();
    rd(1, DA); lit(1, 8'h3C, "data_second"); step();
    rd(1, SA); lit(1, 8'h00, "status_drained"); step();

    // Overfill F21, drain with a held strobe, then underflow
    for (int i = 1; i <= 5; i++) begin wr(1, DA, 8'(i)); step(); end
    rd(1, SA); lit(1, 8'h06, "status_full_ovf");
    rd(0, SA); lit(0, 8'h41, "status_rx4"); step();
    for (int i = 1; i <= 4; i++) begin rd(0, DA); lit(0, 8'(i), "drain_held"); step(); end
    rd(0, DA); lit(0, 8'h00, "underflow_rd"); step();
    rd(0, SA); lit(0, 8'h08, "status_unf"); step();
    wr(1, SA, 8'h04); wr(0, SA, 8'h08); step();
    rd(1, SA); lit(1, 8'h00, "w1c_ovf");
    rd(0, SA); lit(0, 8'h00, "w1c_unf"); step();

    // Push and pop together on a full FIFO
    wr(0, DA, 8'h10); step();
    wr(0, DA, 8'h20); step();
    wr(0, DA, 8'h30); step();
    wr(0, DA, 8'h40); step();
    wr(0, DA, 8'h77); rd(1, DA); lit(1, 8'h10, "full_pushpop"); step();
    rd(0, SA); lit(0, 8'h02, "still_full");
    rd(1, SA); lit(1, 8'h41, "count_kept"); step();
    rd(1, DA); lit(1, 8'h20, "after_full"); step();
    rd(1, DA); lit(1, 8'h30, "after_full"); step();
    rd(1, DA); lit(1, 8'h40, "after_full"); step();
    rd(1, DA); lit(1, 8'h77, "last_is_77"); step();
    rd(0, SA); lit(0, 8'h00, "no_ovf");
    rd(1, SA); lit(1, 8'h00, "empty_again"); step();

    // Push and pop together on an empty FIFO
    wr(0, DA, 8'h55); rd(1, DA); lit(1, 8'h00, "empty_pushpop"); step();
    rd(1, SA); lit(1, 8'h19, "empty_pushpop_st"); step();
    wr(1, SA, 8'h08); step();
    rd(1, DA); lit(1, 8'h55, "pushed_kept"); step();
    rd(1, SA); lit(1, 8'h00, "status_clean"); step();

    // Underflow set beats same-cycle clear
    rd(0, DA); wr(0, SA, 8'h08); lit(0, 8'h00, "unf_vs_w1c_rd"); step();
    rd(0, SA); lit(0, 8'h08, "unf_vs_w1c"); step();
    wr(0, SA, 8'h08); step();
    rd(0, SA); lit(0, 8'h00, "unf_cleared"); step();

    // Flush side2 RX while F21 traffic continues
    wr(0, DA, 8'hC1); wr(1, DA, 8'hD1); step();
    wr(0, DA, 8'hC2); wr(1, DA, 8'hD2); step();
    wr(0, DA, 8'hC3); step();
    rd(1, SA); lit(1, 8'h31, "rx_count3");
    rd(0, SA); lit(0, 8'h21, "rx_count2"); step();
    wr(1, SA, 8'h80); step();
    rd(1, SA); lit(1, 8'h00, "flushed");
    rd(0, SA); lit(0, 8'h21, "peer_untouched"); step();
    rd(0, DA); lit(0, 8'hD1, "peer_data"); step();
    rd(0, DA); lit(0, 8'hD2, "peer_data"); step();

    // Flush beats a push into a full FIFO
    for (int i = 0; i < 4; i++) begin wr(0, DA, 8'hE0 + 8'(i)); step(); end
    wr(0, DA, 8'hE4); wr(1, SA, 8'h80); rd(0, SA); lit(0, 8'h02, "full_before_flush"); step();
    rd(0, SA); lit(0, 8'h00, "flush_no_ovf");
    rd(1, SA); lit(1, 8'h00, "flush_beats_push"); step();

    // Reset mid-transfer with non-matching reads running
    for (int i = 0; i < 3; i++) begin
      wr(0, DA, 8'hF1 + 8'(i)); wr(1, DA, 8'hA1 + 8'(i)); step();
    end
    reset = 1'b1;
    rd(0, 8'h50); lit(0, 8'h00, "nomatch_in_reset");
    rd(1, 8'h50); lit(1, 8'h00, "nomatch_in_reset"); step();
    reset = 1'b0;
    rd(0, SA); lit(0, 8'h00, "post_reset_st");
    rd(1, SA); lit(1, 8'h00, "post_reset_st"); step();
    rd(0, DA); lit(0, 8'h00, "post_reset_rd");
    rd(1, 8'h2A); lit(1, 8'h00, "nomatch_rd"); step();
    rd(0, 8'h27); lit(0, 8'h00, "nomatch_rd"); step();
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
